// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl: power/wake/settle sequencer for one PDM mic channel
// with a first-word fall-through PCM output FIFO and overflow tracking.
module pdm_capture_ctrl #(
  parameter int WAKE_CYCLES = 1024,
  parameter int DISCARD     = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic [7:0]                    hpf_cfg_i,
  output logic                          mic_en_o,
  output logic                          cic_rst_o,
  output logic [7:0]                    hpf_alpha_o,
  input  logic [15:0]                   pcm_in_i,
  input  logic                          pcm_in_vld_i,
  output logic [15:0]                   m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o,
  output logic                          running_o,
  output logic                          overflow_o,
  output logic [7:0]                    ovf_count_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int DW = (DISCARD > 1) ? $clog2(DISCARD) : 1;

  typedef enum logic [1:0] {
    IDLE, WAKE, SETTLE, RUN
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [7:0]    alpha_q, alpha_d;
  logic          mic_en_q, cic_rst_q;
  logic          flush, clr_ovf;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [FW-1:0] fill_q;
  logic          ovf_q;
  logic [7:0]    ovf_cnt_q;
  logic          push, pop, full, do_push, drop;

  // Next-state logic: wake timer, settle discard count, coefficient latch
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    dcnt_d  = dcnt_q;
    alpha_d = alpha_q;
    clr_ovf = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        flush = 1'b1;
        if (enable_i) begin
          state_d = WAKE;
          wcnt_d  = '0;
          alpha_d = hpf_cfg_i;
          clr_ovf = 1'b1;
        end
      end
      WAKE: begin
        if (!enable_i) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (wcnt_q == WW'(WAKE_CYCLES - 1)) begin
          state_d = (DISCARD == 0) ? RUN : SETTLE;
          dcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (!enable_i) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (pcm_in_vld_i) begin
          if (dcnt_q == DW'(DISCARD - 1)) state_d = RUN;
          else dcnt_d = dcnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
          flush   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered mic/decimator controls
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      dcnt_q    <= '0;
      alpha_q   <= 8'd255;
      mic_en_q  <= 1'b0;
      cic_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      dcnt_q    <= dcnt_d;
      alpha_q   <= alpha_d;
      mic_en_q  <= (state_d != IDLE);
      cic_rst_q <= (state_d == IDLE) || (state_d == WAKE);
    end
  end

  // FIFO handshake decode; a strobe on the disable edge is dropped
  always_comb begin
    push    = (state_q == RUN) && enable_i && pcm_in_vld_i;
    pop     = m_valid_o && m_ready_i;
    full    = (fill_q == FW'(FIFO_DEPTH));
    do_push = push && (!full || pop);
    drop    = push && full && !pop;
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= pcm_in_i;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (do_push && !pop)      fill_q <= fill_q + 1'b1;
      else if (pop && !do_push) fill_q <= fill_q - 1'b1;
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst || clr_ovf) begin
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (ovf_cnt_q != 8'd255) ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  assign mic_en_o    = mic_en_q;
  assign cic_rst_o   = cic_rst_q;
  assign hpf_alpha_o = alpha_q;
  assign m_valid_o   = (fill_q != '0);
  assign m_data_o    = m_valid_o ? mem_q[rd_q] : 16'd0;
  assign fill_o      = fill_q;
  assign running_o   = (state_q == RUN);
  assign overflow_o  = ovf_q;
  assign ovf_count_o = ovf_cnt_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// tb_pdm_capture_ctrl: directed sequences with an expected-sample queue
// drained by an independent output monitor.
module tb_pdm_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  hpf_cfg = 8'h00;
  logic        mic_en, cic_rst;
  logic [7:0]  hpf_alpha;
  logic [15:0] pcm_in = 16'h0;
  logic        pcm_vld = 1'b0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [2:0]  fill;
  logic        running, overflow;
  logic [7:0]  ovf_count;

  int checks = 0;
  int passes = 0;
  logic [15:0] exp_q[$];

  pdm_capture_ctrl #(
    .WAKE_CYCLES(16), .DISCARD(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable), .hpf_cfg_i(hpf_cfg),
    .mic_en_o(mic_en), .cic_rst_o(cic_rst), .hpf_alpha_o(hpf_alpha),
    .pcm_in_i(pcm_in), .pcm_in_vld_i(pcm_vld),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .fill_o(fill), .running_o(running), .overflow_o(overflow),
    .ovf_count_o(ovf_count)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted output word must match the queue head
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got %h, required none", m_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (m_data !== e)
          $display("FAIL sb_data: got %h, required %h", m_data, e);
        else
          passes++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    else
      passes++;
  endtask

  task automatic strobe(input logic [15:0] v, input bit keep);
    pcm_in  = v;
    pcm_vld = 1'b1;
    if (keep) exp_q.push_back(v);
    tick(1);
    pcm_vld = 1'b0;
  endtask

  task automatic start_run();
    enable = 1'b1;
    tick(17);
    strobe(16'h1111, 0);
    strobe(16'h2222, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mic_en"}, 32'(mic_en), 0);
    chk({tag, "_cic_rst"}, 32'(cic_rst), 1);
    chk({tag, "_hpf"}, 32'(hpf_alpha), 255);
    chk({tag, "_valid"}, 32'(m_valid), 0);
    chk({tag, "_data"}, 32'(m_data), 0);
    chk({tag, "_fill"}, 32'(fill), 0);
    chk({tag, "_running"}, 32'(running), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_ovf_cnt"}, 32'(ovf_count), 0);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    chk_reset("rst");

    // T1 wake timing, settle discard, first sample latency
    hpf_cfg = 8'hF0;
    enable  = 1'b1;
    tick(1);
    chk("t1_mic_on", 32'(mic_en), 1);
    tick(15);
    chk("t1_cic_hold15", 32'(cic_rst), 1);
    tick(1);
    chk("t1_cic_rel16", 32'(cic_rst), 0);
    chk("t1_settle_run", 32'(running), 0);
    strobe(16'h1111, 0);
    chk("t1_drop1_fill", 32'(fill), 0);
    strobe(16'h2222, 0);
    chk("t1_running", 32'(running), 1);
    chk("t1_drop2_valid", 32'(m_valid), 0);
    strobe(16'h1234, 1);
    chk("t1_valid", 32'(m_valid), 1);
    chk("t1_head", 32'(m_data), 32'h1234);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    chk("t1_fill0", 32'(fill), 0);

    // T2 coefficient only updates on idle exit
    chk("t2_alpha_f0", 32'(hpf_alpha), 32'hF0);
    hpf_cfg = 8'h10;
    tick(2);
    chk("t2_alpha_hold", 32'(hpf_alpha), 32'hF0);
    enable = 1'b0;
    tick(1);
    chk("t2_idle", 32'(running), 0);
    start_run();
    chk("t2_alpha_10", 32'(hpf_alpha), 32'h10);
    chk("t2_running", 32'(running), 1);

    // T3 overflow with stalled consumer
    for (int i = 1; i <= 6; i++) strobe(16'(i), i <= 4);
    chk("t3_fill", 32'(fill), 4);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_ovf_cnt", 32'(ovf_count), 2);
    m_ready = 1'b1;
    tick(4);
    m_ready = 1'b0;
    chk("t3_drained", 32'(fill), 0);

    // T4 simultaneous push and pop while full
    enable = 1'b0;
    tick(1);
    start_run();
    chk("t4_ovf_clr", 32'(overflow), 0);
    for (int i = 1; i <= 4; i++) strobe(16'hA0 + 16'(i), 1);
    chk("t4_full", 32'(fill), 4);
    m_ready = 1'b1;
    strobe(16'hA5, 1);
    m_ready = 1'b0;
    chk("t4_fill_hold", 32'(fill), 4);
    chk("t4_no_ovf", 32'(overflow), 0);
    m_ready = 1'b1;
    tick(4);
    m_ready = 1'b0;
    chk("t4_drained", 32'(fill), 0);

    // T5 disable flushes the FIFO
    for (int i = 0; i < 3; i++) strobe(16'hC0 + 16'(i), 0);
    chk("t5_fill3", 32'(fill), 3);
    enable = 1'b0;
    tick(1);
    chk("t5_running", 32'(running), 0);
    chk("t5_valid", 32'(m_valid), 0);
    chk("t5_fill", 32'(fill), 0);
    chk("t5_mic_en", 32'(mic_en), 0);
    chk("t5_cic_rst", 32'(cic_rst), 1);

    // T6 reset in SETTLE, then counter saturation
    enable = 1'b1;
    tick(17);
    chk("t6_in_settle", 32'(cic_rst), 0);
    rst = 1'b1;
    tick(1);
    chk_reset("t6");
    enable  = 1'b0;
    tick(1);
    rst     = 1'b0;
    hpf_cfg = 8'h33;
    start_run();
    for (int i = 0; i < 304; i++) strobe(16'(i), 0);
    chk("t6_sat_cnt", 32'(ovf_count), 255);
    chk("t6_sat_ovf", 32'(overflow), 1);
    enable = 1'b0;
    tick(1);
    chk("t6_cnt_kept", 32'(ovf_count), 255);
    chk("t6_sb_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
